// File: rtl/ivs_mst.sv
// ivs_mst: single-outstanding AHB-Lite initiator, one valid/ready command -> one SINGLE word transfer -> one response.
// Latency: zero-wait transfer gives rsp_valid 3 edges after accept (accept, address phase, data phase); +1 per wait state.
// Backpressure: cmd_ready is low from accept until the FSM returns to IDLE; rsp_* is a one-cycle pulse with no backpressure.
//
// Ports:
//   hclk/hrst_n             clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_write, cmd_addr, cmd_wdata qualify it
//   rsp_valid               one-cycle response pulse with rsp_rdata, rsp_err, rsp_timeout
//   busy                    FSM not in IDLE
//   htrans..hprot           registered AHB-Lite master outputs (hsize/hburst/hprot constant)
//   hready/hresp/hrdata     AHB-Lite slave response inputs
module ivs_mst #(
  parameter int         TIMEOUT_CYC = 256,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic [1:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t         r_state,       w_state_nxt;
  logic [1:0]     r_htrans,      w_htrans_nxt;
  logic           r_hwrite,      w_hwrite_nxt;
  logic [31:0]    r_haddr,       w_haddr_nxt;
  logic [31:0]    r_hwdata,      w_hwdata_nxt;
  logic [31:0]    r_wdata,       w_wdata_nxt;
  logic [CW-1:0]  r_cnt,         w_cnt_nxt;
  logic           r_err,         w_err_nxt;
  logic           r_rsp_valid,   w_rsp_valid_nxt;
  logic [31:0]    r_rsp_rdata,   w_rsp_rdata_nxt;
  logic           r_rsp_err,     w_rsp_err_nxt;
  logic           r_rsp_timeout, w_rsp_timeout_nxt;

  logic w_hresp_err;
  logic w_err_any;
  logic w_unused_addr_lsb;

  // Any non-OKAY encoding is handled as ERROR.
  assign w_hresp_err       = (hresp != 2'b00);
  assign w_err_any         = r_err | w_hresp_err;
  assign w_unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_state       <= S_IDLE;
      r_htrans      <= HTRANS_IDLE;
      r_hwrite      <= 1'b0;
      r_haddr       <= 32'h0;
      r_hwdata      <= 32'h0;
      r_wdata       <= 32'h0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'h0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_htrans      <= w_htrans_nxt;
      r_hwrite      <= w_hwrite_nxt;
      r_haddr       <= w_haddr_nxt;
      r_hwdata      <= w_hwdata_nxt;
      r_wdata       <= w_wdata_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err         <= w_err_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_htrans_nxt      = r_htrans;
    w_hwrite_nxt      = r_hwrite;
    w_haddr_nxt       = r_haddr;
    w_hwdata_nxt      = r_hwdata;
    w_wdata_nxt       = r_wdata;
    w_cnt_nxt         = r_cnt;
    w_err_nxt         = r_err;
    // Response fields are pulses: zero unless a response is issued this edge.
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = 32'h0;
    w_rsp_err_nxt     = 1'b0;
    w_rsp_timeout_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_wdata_nxt  = cmd_wdata;
          w_haddr_nxt  = {cmd_addr[31:2], 2'b00};
          w_hwrite_nxt = cmd_write;
          w_htrans_nxt = HTRANS_NONSEQ;
          w_state_nxt  = S_ADDR;
        end
      end

      S_ADDR: begin
        // Address phase stays on the bus until the slave takes it.
        if (hready) begin
          w_htrans_nxt = HTRANS_IDLE;
          w_hwdata_nxt = r_hwrite ? r_wdata : 32'h0;
          w_cnt_nxt    = '0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_DATA;
        end
      end

      S_DATA: begin
        if (hready) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_err_any;
          w_rsp_rdata_nxt = (!r_hwrite && !w_err_any) ? hrdata : 32'h0;
          w_state_nxt     = S_IDLE;
        end else begin
          if (r_cnt != TO_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          // First cycle of the two-cycle ERROR response.
          if (w_hresp_err) begin
            w_err_nxt = 1'b1;
          end
          // This wait edge brings the count to TIMEOUT_CYC: give up, but
          // keep the bus quiet until the slave finally completes.
          if (r_cnt == TO_LAST) begin
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
            w_state_nxt       = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (hready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign htrans      = r_htrans;
  assign hwrite      = r_hwrite;
  assign haddr       = r_haddr;
  assign hwdata      = r_hwdata;
  assign hsize       = 2'b10;
  assign hburst      = 3'b000;
  assign hprot       = HPROT_VAL;

endmodule

// File: doc/ivs_mst.md
Name: ivs_mst

Overview:
- Single-outstanding AHB-Lite initiator that turns a simple valid/ready command port into single-word AHB transfers.
- Returns one response per command: read data, error flag, timeout flag.
- Sits between firmware/test sequencers or DMA control logic and the IVS register-slave bus. Used to program glb_ctrl and cfg_par registers and to read them back.

Parameters:
- TIMEOUT_CYC, 256, data-phase wait cycles (hready low) tolerated before the transfer is reported as timed out; legal range 2..65535.
- HPROT_VAL, 4'b0011, constant driven on hprot (non-cacheable, non-bufferable, privileged data).

Ports:
- hclk  in  1  bus clock, rising edge.
- hrst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address; bits [1:0] ignored, driven 0 on haddr.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  slave returned ERROR.
- rsp_timeout  out  1  data phase exceeded TIMEOUT_CYC.
- busy  out  1  state != IDLE.
- htrans  out  2  2'b10 NONSEQ or 2'b00 IDLE only.
- hwrite  out  1  transfer direction.
- haddr  out  32  transfer address.
- hwdata  out  32  write data, data phase.
- hsize  out  2  constant 2'b10 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- hready  in  1  bus ready (slave hready_out).
- hresp  in  2  2'b00 OKAY, 2'b01 ERROR; others treated as ERROR.
- hrdata  in  32  read data.

Behaviour:
- Reset: all flops clear asynchronously on hrst_n low; release is synchronous to hclk at the top level.
- Reset values: state=IDLE, htrans=00, hwrite=0, haddr=0, hwdata=0, rsp_*=0, busy=0, cmd_ready=1, timeout counter=0.
- Reset mid-transfer discards the transfer; no response is generated.
- All AHB outputs and rsp_* are registered.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept at edge E0: latch cmd_write and cmd_wdata; haddr={cmd_addr[31:2],2'b00}; hwrite=cmd_write; htrans=NONSEQ; go to ADDR.
- ADDR:
  - cmd_ready=0; htrans held NONSEQ and haddr/hwrite held stable until an edge with hready=1 (E1).
  - At E1: htrans=IDLE; hwdata=latched wdata (writes; 0 for reads); clear counter; go to DATA.
- DATA:
  - At each edge with hready=0: counter increments.
  - hresp!=00 while hready=0 sets a sticky err flag (first cycle of the two-cycle ERROR response).
  - Edge E2 with hready=1 ends the transfer. The cycle after E2:
    - rsp_valid=1;
    - rsp_err = sticky err OR (hresp!=00 at E2);
    - rsp_rdata = hrdata sampled at E2 for an error-free read, else 0;
    - state returns to IDLE.
  - Timeout: if the counter reaches TIMEOUT_CYC with hready still 0, the next cycle has rsp_valid=1, rsp_timeout=1, rsp_err=0, rsp_rdata=0, and the state goes to DRAIN.
- DRAIN:
  - htrans=IDLE, cmd_ready=0.
  - Waits for an edge with hready=1 (the bus is never re-driven mid-transfer), then goes to IDLE with no further response.
- Latency: zero-wait write or read = 3 edges from accept to rsp_valid high (E0 accept, E1 address phase, E2 data phase, pulse after E2).
- Back-to-back: cmd_ready is high in the same cycle rsp_valid is high, so a new command may be accepted then; peak rate is one transfer per 3 cycles.
- rsp_valid is never asserted for more than one cycle per command.
- Exactly one response per accepted command, except when reset intervenes.
- Counter saturates at TIMEOUT_CYC; its width is clog2(TIMEOUT_CYC+1).
- No backpressure on rsp_*; the consumer must sample on rsp_valid.

Test Plan:
- Write cmd_addr=0x100, cmd_wdata=0xDEADBEEF, zero-wait slave -> cycle after E0: htrans=10, haddr=0x100, hwrite=1; after E1: htrans=00, hwdata=0xDEADBEEF; after E2: rsp_valid=1, rsp_err=0, rsp_timeout=0.
- Read 0x100 from IVS slave (one hready_out-low cycle after a read) -> counter=1, rsp_valid 4 edges after accept, rsp_rdata=0xDEADBEEF.
- Slave drives hresp=01 with hready=0 for one cycle, then hresp=01 with hready=1 on read of 0x200 -> rsp_err=1, rsp_rdata=0, FSM back in IDLE, next command accepted.
- TIMEOUT_CYC=4, hready held 0 in data phase -> rsp_timeout=1 after the 4th wait edge; busy stays 1 and cmd_ready stays 0 until hready=1 is sampled, then IDLE.
- Four commands presented with cmd_valid held high (W 0x000=1, W 0x104=5, R 0x104, R 0x000), zero-wait -> accepts every 3 cycles, reads return 5 and 1, htrans never NONSEQ in consecutive cycles.
- Assert hrst_n=0 during DATA of a write (unsynchronised to hclk) -> outputs reach reset values immediately, no rsp_valid; after release the first command completes normally.
